// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter and its clear sequencer.
package ram_arb_pkg;

  localparam int RAM_AW = 8;
  localparam int RAM_DW = 8;
  localparam logic [RAM_DW-1:0] CLR_VALUE = 8'h00;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_CLR,
    GNT_CPU,
    GNT_DBG
  } grant_e;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sweep sequencer: walks every RAM address once after a start pulse,
// reporting busy until the last address has been written.
module ram_clear_seq
  import ram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic [RAM_AW-1:0] addr
);

  logic              busy_q, busy_d;
  logic [RAM_AW-1:0] addr_q, addr_d;

  always_comb begin
    busy_d = busy_q;
    addr_d = addr_q;
    if (busy_q) begin
      // The address wraps to 0 on the same edge that ends the sweep.
      addr_d = addr_q + RAM_AW'(1);
      if (addr_q == '1) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      addr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      addr_q <= '0;
    end else begin
      busy_q <= busy_d;
      addr_q <= addr_d;
    end
  end

  assign busy = busy_q;
  assign addr = addr_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port 256x8 data RAM between the CPU, the debug/loader port
// and the hardware clear engine, and routes read data back to its requester.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [RAM_DW-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [RAM_AW-1:0] dbg_addr,
  input  logic [RAM_DW-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [RAM_DW-1:0] dbg_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_data,
  output logic              ram_wren,
  input  logic [RAM_DW-1:0] ram_q
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [RAM_AW-1:0] clr_addr;
  grant_e            gnt_sel;
  logic [3:0]        starve_q, starve_d;
  owner_e            owner_q, owner_d;
  logic              rd_q, rd_d;

  ram_clear_seq u_clear (
    .clk  (Clock),
    .reset(Reset),
    .start(clr_start),
    .busy (clr_busy),
    .addr (clr_addr)
  );

  always_comb begin
    gnt_sel = GNT_NONE;
    if (clr_busy) begin
      gnt_sel = GNT_CLR;
    end else if (dbg_req && (starve_q == STARVE_LIM)) begin
      gnt_sel = GNT_DBG;
    end else if (cpu_req) begin
      gnt_sel = GNT_CPU;
    end else if (dbg_req) begin
      gnt_sel = GNT_DBG;
    end
  end

  assign cpu_gnt   = (gnt_sel == GNT_CPU);
  assign dbg_gnt   = (gnt_sel == GNT_DBG);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  always_comb begin
    ram_addr = cpu_addr;
    ram_data = '0;
    ram_wren = 1'b0;
    case (gnt_sel)
      GNT_CLR: begin
        ram_addr = clr_addr;
        ram_data = CLR_VALUE;
        ram_wren = 1'b1;
      end
      GNT_CPU: begin
        ram_addr = cpu_addr;
        ram_data = cpu_wdata;
        ram_wren = cpu_we;
      end
      GNT_DBG: begin
        ram_addr = dbg_addr;
        ram_data = dbg_wdata;
        ram_wren = dbg_we;
      end
      default: ;
    endcase
  end

  // Starvation count only advances while the debug port is actually waiting
  // behind a CPU grant; clear cycles freeze it.
  always_comb begin
    starve_d = starve_q;
    if (!clr_busy) begin
      if (!dbg_req || dbg_gnt) begin
        starve_d = '0;
      end else if (cpu_gnt) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_comb begin
    rd_d    = 1'b0;
    owner_d = owner_q;
    if (cpu_gnt) begin
      owner_d = OWN_CPU;
      rd_d    = ~cpu_we;
    end else if (dbg_gnt) begin
      owner_d = OWN_DBG;
      rd_d    = ~dbg_we;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      starve_q <= '0;
      owner_q  <= OWN_CPU;
      rd_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
      rd_q     <= rd_d;
    end
  end

  // Gating with Reset drops a read whose return cycle coincides with reset.
  assign cpu_rvalid = rd_q && (owner_q == OWN_CPU) && !Reset;
  assign dbg_rvalid = rd_q && (owner_q == OWN_DBG) && !Reset;
  assign cpu_rdata  = ram_q;
  assign dbg_rdata  = ram_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: a behavioural RAM, a cycle-level
// reference model checked every cycle, and directed literal checks.
module tb_ram_arbiter;

  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_req, cpu_we, dbg_req, dbg_we, clr_start;
  logic [7:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic       cpu_gnt, cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid, clr_busy, ram_wren;
  logic [7:0] cpu_rdata, dbg_rdata, ram_addr, ram_data;
  logic [7:0] ram_q = 8'h00;
  logic [7:0] ram_mem [256] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .Clock(clk), .Reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .clr_start(clr_start), .clr_busy(clr_busy),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
  );

  // Synchronous single-port RAM with registered output.
  always @(posedge clk) begin
    if (ram_wren === 1'b1) ram_mem[ram_addr] <= ram_data;
    ram_q <= ram_mem[ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model state: remaining clear cycles, next clear address,
  // consecutive CPU wins over a waiting debug port, and pending read return.
  int         m_clr_left = 0;
  int         m_clr_next = 0;
  int         m_wait = 0;
  int         m_pend = 0;
  logic [7:0] m_pend_data = 8'h00;
  logic [7:0] m_mem [256] = '{default: 8'h00};
  logic       e_cpu, e_dbg, e_wren, e_busy;
  logic [7:0] e_addr, e_data;

  always @(negedge clk) begin
    e_busy = (m_clr_left > 0);
    e_cpu  = 1'b0;
    e_dbg  = 1'b0;
    if (!e_busy) begin
      if (dbg_req && m_wait >= STARVE_MAX) e_dbg = 1'b1;
      else if (cpu_req) e_cpu = 1'b1;
      else if (dbg_req) e_dbg = 1'b1;
    end
    e_wren = e_busy ? 1'b1 : (e_cpu ? cpu_we : (e_dbg ? dbg_we : 1'b0));
    e_addr = e_busy ? 8'(m_clr_next) : (e_dbg ? dbg_addr : cpu_addr);
    e_data = e_busy ? 8'h00 : (e_cpu ? cpu_wdata : dbg_wdata);

    if (chk_en) begin
      checkOutput("m_cpu_gnt", cpu_gnt, e_cpu);
      checkOutput("m_dbg_gnt", dbg_gnt, e_dbg);
      checkOutput("m_cpu_stall", cpu_stall, cpu_req && !e_cpu);
      checkOutput("m_clr_busy", clr_busy, e_busy);
      checkOutput("m_cpu_rvalid", cpu_rvalid, (m_pend == 1) && !reset);
      checkOutput("m_dbg_rvalid", dbg_rvalid, (m_pend == 2) && !reset);
      checkOutput("m_ram_wren", ram_wren, e_wren);
      checkOutput("m_ram_addr", ram_addr, e_addr);
      if (e_wren) checkOutput("m_ram_data", ram_data, e_data);
      if (m_pend == 1 && !reset) checkOutput("m_cpu_rdata", cpu_rdata, m_pend_data);
      if (m_pend == 2 && !reset) checkOutput("m_dbg_rdata", dbg_rdata, m_pend_data);
    end

    if (reset) begin
      m_clr_left = 0;
      m_clr_next = 0;
      m_wait     = 0;
      m_pend     = 0;
    end else begin
      m_pend = 0;
      if (e_cpu && !cpu_we) begin m_pend = 1; m_pend_data = m_mem[cpu_addr]; end
      if (e_dbg && !dbg_we) begin m_pend = 2; m_pend_data = m_mem[dbg_addr]; end
      if (!e_busy) begin
        if (!dbg_req || e_dbg) m_wait = 0;
        else if (e_cpu) m_wait++;
      end
      if (e_busy) begin
        m_clr_left--;
        m_clr_next = (m_clr_next + 1) % 256;
      end else if (clr_start) begin
        m_clr_left = 256;
        m_clr_next = 0;
      end
    end
    if (e_wren) m_mem[e_addr] = e_data;
  end

  task automatic applyStimulus(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                               input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd,
                               input logic st);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    clr_start = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int   stalls;
  int   busy_cnt;
  logic [7:0] rd_addrs [6] = '{8'd40, 8'd45, 8'd48, 8'd51, 8'd60, 8'd70};
  logic [7:0] rd_exp   [6] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA5};

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_clr_busy", clr_busy, 0);
    checkOutput("reset_cpu_rvalid", cpu_rvalid, 0);
    checkOutput("reset_dbg_rvalid", dbg_rvalid, 0);
    checkOutput("reset_ram_wren", ram_wren, 0);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // CPU write then read-back
    applyStimulus(1, 1, 8'h10, 8'h5A, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("cpu_wr_gnt", cpu_gnt, 1);
    tick();
    applyStimulus(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("cpu_rd_gnt", cpu_gnt, 1);
    checkOutput("cpu_wr_no_rvalid", cpu_rvalid, 0);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("cpu_rd_rvalid", cpu_rvalid, 1);
    checkOutput("cpu_rd_data", cpu_rdata, 8'h5A);
    tick();

    // Both ports contending: CPU x4, DBG x1
    applyStimulus(1, 0, 8'h10, 8'h00, 1, 0, 8'h10, 8'h00, 0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      checkOutput("starve_cpu_gnt", cpu_gnt, (i % 5) != 4);
      checkOutput("starve_dbg_gnt", dbg_gnt, (i % 5) == 4);
      checkOutput("starve_cpu_stall", cpu_stall, (i % 5) == 4);
      tick();
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    tick();

    // Debug write/read of 0x22 with the CPU idle
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 1, 8'h22, 8'h3C, 0);
    @(negedge clk); checkOutput("dbg_wr_gnt", dbg_gnt, 1);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h22, 8'h00, 0);
    @(negedge clk); checkOutput("dbg_rd_gnt", dbg_gnt, 1);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("dbg_rvalid", dbg_rvalid, 1);
    checkOutput("dbg_rdata", dbg_rdata, 8'h3C);
    checkOutput("dbg_rd_cpu_rvalid", cpu_rvalid, 0);
    tick();

    // Full clear with a CPU request pending
    applyStimulus(1, 1, 8'h00, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
    tick();
    applyStimulus(1, 1, 8'hFF, 8'hFF, 0, 0, 8'h00, 8'h00, 0);
    tick();
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
    @(negedge clk); checkOutput("clr_start_cycle_gnt", cpu_gnt, 1);
    tick();
    applyStimulus(1, 0, 8'hFF, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("pre_clr_rvalid", cpu_rvalid, 1);
    checkOutput("pre_clr_rdata", cpu_rdata, 8'hFF);
    stalls = 0;
    while (!cpu_gnt && stalls < 300) begin
      stalls++;
      tick();
      @(negedge clk);
    end
    checkOutput("clr_stall_cycles", stalls, 256);
    checkOutput("clr_busy_done", clr_busy, 0);
    tick();
    applyStimulus(1, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("clr_ff_rvalid", cpu_rvalid, 1);
    checkOutput("clr_ff_rdata", cpu_rdata, 8'h00);
    tick();
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    @(negedge clk); checkOutput("clr_00_rdata", cpu_rdata, 8'h00);
    tick();

    // Second start pulse mid-sweep is ignored
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
    tick();
    busy_cnt = 0;
    for (int k = 1; k <= 300; k++) begin
      clr_start = (k == 100);
      @(negedge clk);
      if (!clr_busy) break;
      busy_cnt++;
      tick();
    end
    clr_start = 1'b0;
    checkOutput("repulse_busy_cycles", busy_cnt, 256);
    tick();

    // Reset aborts a sweep part-way
    for (int a = 40; a <= 70; a++) begin
      applyStimulus(1, 1, 8'(a), 8'hA5, 0, 0, 8'h00, 8'h00, 0);
      tick();
    end
    applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 1);
    tick();
    clr_start = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      reset = (k == 50);
      tick();
    end
    reset = 1'b0;
    @(negedge clk); checkOutput("abort_clr_busy", clr_busy, 0);
    checkOutput("abort_no_rvalid", cpu_rvalid, 0);
    tick();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 0, rd_addrs[i], 8'h00, 0, 0, 8'h00, 8'h00, 0);
      tick();
      applyStimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      @(negedge clk);
      checkOutput("abort_rvalid", cpu_rvalid, 1);
      checkOutput("abort_rdata", cpu_rdata, rd_exp[i]);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbiter and sequencer for the single-port 256×8 synchronous data RAM (`lpm_ram_256_8`). It shares the RAM between the CPU load/store path and a debug/loader port (keypad-driven preload, display readback), and adds a hardware clear engine that zeroes the whole RAM on request. It sits between the requesters and the RAM ports `address`/`data`/`wren`/`q`, and returns per-requester grant and read-valid strobes.

## Interface
Parameters:
- `STARVE_MAX`, default 4: number of consecutive CPU grants while the debug port waits before the debug port is forced a slot. Legal range 1..15.

Ports:
- `Clock`  in  1  single system clock; everything is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  CPU access request.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  8  CPU address.
- `cpu_wdata`  in  8  CPU write data.
- `cpu_gnt`  out  1  access performed this cycle (combinational).
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`.
- `cpu_rvalid`  out  1  registered; read data valid.
- `cpu_rdata`  out  8  RAM `q`, meaningful when `cpu_rvalid` is high.
- `dbg_req`, `dbg_we`, `dbg_addr[7:0]`, `dbg_wdata[7:0]`  in  debug request bundle, same meaning as the CPU bundle.
- `dbg_gnt`  out  1; `dbg_rvalid`  out  1; `dbg_rdata`  out  8  same meaning as the CPU outputs.
- `clr_start`  in  1  one-cycle pulse that starts a full clear.
- `clr_busy`  out  1  registered; clear sweep in progress.
- `ram_addr`  out  8; `ram_data`  out  8; `ram_wren`  out  1  drive the RAM (combinational mux).
- `ram_q`  in  8  RAM registered output.

## Operation
- A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt` high. The access is committed on the edge that ends the grant cycle. At most one grant per cycle.
- Priority each cycle:
  1. Clear engine, while `clr_busy`.
  2. Debug, if `dbg_req` and `starve_cnt == STARVE_MAX`.
  3. CPU, if `cpu_req`.
  4. Debug, if `dbg_req`.
- `starve_cnt` is 4 bits, reset 0.
  - Increments on every cycle where the CPU is granted and `dbg_req` is high.
  - Clears when the debug port is granted or `dbg_req` is low.
  - Holds during clear cycles.
- Clear engine:
  - `clr_start` while idle sets `clr_busy` and sets `clr_addr` to 0 on the next edge.
  - Each busy cycle drives `ram_addr=clr_addr`, `ram_data=0x00`, `ram_wren=1`, then increments `clr_addr`.
  - After the cycle that writes address 255, `clr_busy` drops. The sweep takes exactly 256 busy cycles.
  - `clr_start` while busy is ignored.
- When nothing is granted: `ram_wren=0`, `ram_addr` holds the CPU address, `ram_data=0`.
- Read return: a one-bit owner tag (CPU or debug) and a read flag are registered at the grant. The next cycle, the owner's `rvalid` pulses high for one cycle with `rdata = ram_q`.
- Writes produce no `rvalid`.

## Timing
- Reset values: `clr_busy=0`, `clr_addr=0`, `starve_cnt=0`, both `rvalid=0`, owner tag = CPU.
- Read latency: data arrives 1 cycle after `gnt`. Back-to-back reads from either port are sustained at one per cycle.
- `clr_start` in the same cycle as a request: that request is still arbitrated normally this cycle. The clear owns the RAM from the next cycle for 256 cycles, and both ports stall throughout.
- `Reset` during a sweep aborts it immediately: `clr_busy=0`, the RAM is left partially cleared, and no `rvalid` follows.
- `Reset` in the cycle after a read grant suppresses that read's `rvalid`.
- Address wrap: `clr_addr` 255 → 0 coincides with `clr_busy` falling.

## Structure
- Shared package `ram_arb_pkg`: owner encoding (`OWN_CPU`, `OWN_DBG`), `RAM_AW=8`, `RAM_DW=8`, `CLR_VALUE=8'h00`.
- One sub-module `ram_clear_seq`: the `clr_busy`/`clr_addr` counter with start/done.
- Arbitration, starvation counter and read-return tagging stay in the top.

## Test plan
- After reset, CPU writes 0x5A to addr 0x10, then reads it: `cpu_gnt` is high on both requests, and `cpu_rvalid` is high with `cpu_rdata=0x5A` one cycle after the read grant.
- `cpu_req` and `dbg_req` held continuously, `STARVE_MAX=4`: grants follow the pattern CPU×4, DBG×1, repeating. `cpu_stall` is high only in the DBG cycles.
- Debug reads 0x22 while the CPU is idle: `dbg_gnt` is the same cycle, `dbg_rvalid` is the next cycle with the stored value, and `cpu_rvalid` stays 0.
- Write 0xFF to addrs 0x00 and 0xFF, then pulse `clr_start` with `cpu_req` pending:
  - the CPU is stalled for 256 cycles, and `clr_busy` falls after the write to 0xFF;
  - reads of 0x00 and 0xFF then return 0x00.
- `clr_start` pulsed again at cycle 100 of a sweep: ignored, and the sweep still ends at 256 cycles.
- Reset asserted at cycle 50 of a sweep: `clr_busy=0` next cycle. Addrs 0..48 read 0x00, and addrs above 50 keep their old contents.
